uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares one uart_tx transmitter between NUM_REQ byte requesters using round-robin arbitration.
//   Captures the granted byte and issues a one-cycle tx_start. Then tracks tx_busy until the frame completes.
//   Sits between client logic (console, debug dump, status reporter) and the uart wrapper's TX port.
// PARAMETERS
//   NUM_REQ       4    number of requesters, 2..8
//   BUSY_TIMEOUT  16   cycles to wait for tx_busy to rise after tx_start before treating the frame as done
// PORTS
//   clk        in   1          system clock; single clock domain
//   rst_n      in   1          asynchronous, active-low reset
//   req_valid  in   NUM_REQ    requester i has a byte pending
//   req_data   in   8*NUM_REQ  byte of requester i at [8*i+:8]; held stable while valid and not acked
//   req_lock   in   NUM_REQ    requester i asks to keep the grant (used only with UART_ARB_LOCK_EN)
//   req_ack    out  NUM_REQ    one-cycle pulse: byte of requester i captured
//   tx_busy    in   1          from uart_tx
//   tx_data    out  8          to uart_tx; holds the captured byte
//   tx_start   out  1          to uart_tx; one-cycle pulse
//   grant_id   out  3          index of the last granted requester
//   arb_busy   out  1          high in every state except IDLE
// BEHAVIOUR
//   Reset values: req_ack=0, tx_start=0, tx_data=0, grant_id=0, arb_busy=0, rr_ptr=0, state=IDLE.
//   Reset is asynchronous. Asserting rst_n mid-frame drops tx_start and aborts the sequence; the uart_tx frame in flight is not recalled.
//   FSM states and transitions:
//     IDLE  -> GRANT when any req_valid && !tx_busy. The search starts at rr_ptr and wraps modulo NUM_REQ.
//              If tx_busy is high (e.g. at reset release), stay in IDLE.
//     GRANT (one cycle): tx_data<=req_data[g], grant_id<=g, req_ack[g]=1, tx_start=1, rr_ptr<=(g+1)%NUM_REQ.
//           Next state is WAIT_HI.
//     WAIT_HI -> WAIT_LO on tx_busy=1. If BUSY_TIMEOUT cycles pass without tx_busy, go directly to IDLE.
//     WAIT_LO -> IDLE on tx_busy=0.
//   Latency: valid sampled high in IDLE at edge N -> req_ack and tx_start high in cycle N+1.
//   Requester contract: drop valid or present the next byte in the cycle after ack.
//     Valid is not resampled before the arbiter returns to IDLE (at least 3 cycles later).
//   Fairness: after a grant to g, g has the lowest priority; with all requesters valid, grants go 0,1,2,3,0...
//   Boundary cases:
//     - rr_ptr wraps from NUM_REQ-1 to 0.
//     - A valid deasserted before ack gets no ack; the arbiter never grants a non-valid requester.
//     - Simultaneous valids resolve in one cycle. No bubble beyond the IDLE cycle between frames.
//     - tx_data is stable from GRANT until the next GRANT.
//     - grant_id is zero-extended when NUM_REQ<8.
// CONFIGURATION
//   UART_ARB_LOCK_EN defined:
//     - If req_lock[grant_id] is high when WAIT_LO exits, the next grant is reserved for grant_id.
//     - rr_ptr is not advanced in that case.
//     - Other valids are ignored until the locked requester sends a byte with req_lock low.
//     - Reserved but no valid: the arbiter waits in IDLE indefinitely. Locking is the client's responsibility.
//   UART_ARB_LOCK_EN undefined: the req_lock port is present but ignored; plain round-robin per byte.
// STRUCTURE
//   Package uart_arb_pkg:
//     - state enum {IDLE, GRANT, WAIT_HI, WAIT_LO}
//     - NUM_REQ_MAX=8
//     - GRANT_W=3
//   Sub-module rr_arbiter: combinational round-robin pick.
//     - Inputs: req vector, rr_ptr. Outputs: found, g.
//     - The FSM, timeout counter, data register and lock logic live in uart_tx_arbiter.
// TESTING
//   1. Single requester 2 sends 0xA5 with tx_busy modelled (rises 1 cycle after start, high 20 cycles):
//      one ack[2], one tx_start, tx_data=0xA5, grant_id=2.
//   2. All four valid with bytes 0x10..0x13: tx_data sequence 0x10,0x11,0x12,0x13; then ptr wraps and 0 is granted next.
//   3. tx_busy held high at reset release with valid[0] set: no tx_start until tx_busy falls; then ack[0] follows 1 cycle later.
//   4. uart model never raises tx_busy: the arbiter returns to IDLE after 16 cycles and the next requester is granted.
//   5. rst_n pulsed low during WAIT_LO: all outputs are 0 immediately; after release, 0 is the first granted requester.
//   6. With UART_ARB_LOCK_EN: requester 1 sends 3 bytes with lock=1,1,0 while 0 and 3 are valid: bytes 1,1,1 then 3,0.
//      Without the macro the same stimulus gives 1,3,0,1,...

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART TX arbiter: FSM state encoding,
// grant index width and the round-robin pointer advance helper.
package uart_arb_pkg;

    localparam int NUM_REQ_MAX = 8;
    localparam int GRANT_W     = 3;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        WAIT_HI,
        WAIT_LO
    } arb_state_e;

    // Position after g, wrapping from num_req-1 back to 0.
    function automatic logic [GRANT_W-1:0] rr_next(input logic [GRANT_W-1:0] g,
                                                   input int                  num_req);
        return (int'(g) == num_req - 1) ? '0 : g + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set bit of req at or after rr_ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] rr_ptr,
    output logic               found,
    output logic [GRANT_W-1:0] g
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;

    // Rotating the doubled vector puts rr_ptr at bit 0, so the lowest set
    // bit of req_rot is the highest-priority requester.
    assign req_dbl = {req, req};
    assign req_rot = NUM_REQ'(req_dbl >> rr_ptr);

    always_comb begin
        int idx;
        found = 1'b0;
        g     = '0;
        idx   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                found = 1'b1;
                g     = GRANT_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx between NUM_REQ byte requesters.
// Optional grant locking is compiled in with `define UART_ARB_LOCK_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_lock,
    output logic [NUM_REQ-1:0]   req_ack,
    input  logic                 tx_busy,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    output logic [GRANT_W-1:0]   grant_id,
    output logic                 arb_busy
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    arb_state_e           state_q, state_d;
    logic [GRANT_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GRANT_W-1:0]   grant_id_q, grant_id_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic [NUM_REQ-1:0]   req_ack_q, req_ack_d;
    logic                 tx_start_q, tx_start_d;
    logic [CNT_W-1:0]     tmo_cnt_q, tmo_cnt_d;

    logic [NUM_REQ-1:0]   arb_req;
    logic                 arb_found;
    logic [GRANT_W-1:0]   arb_g;
    logic                 lock_active;

`ifdef UART_ARB_LOCK_EN
    logic                 lock_q, lock_d;
    logic [NUM_REQ-1:0]   grant_mask;

    // While reserved, only the previous grantee is visible to the picker.
    assign grant_mask  = NUM_REQ'(1) << grant_id_q;
    assign arb_req     = lock_q ? (req_valid & grant_mask) : req_valid;
    assign lock_active = lock_q;
`else
    logic                 unused_lock;

    assign unused_lock = ^req_lock;
    assign arb_req     = req_valid;
    assign lock_active = 1'b0;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req    (arb_req),
        .rr_ptr (rr_ptr_q),
        .found  (arb_found),
        .g      (arb_g)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            tx_data_q  <= '0;
            req_ack_q  <= '0;
            tx_start_q <= 1'b0;
            tmo_cnt_q  <= '0;
`ifdef UART_ARB_LOCK_EN
            lock_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            tx_data_q  <= tx_data_d;
            req_ack_q  <= req_ack_d;
            tx_start_q <= tx_start_d;
            tmo_cnt_q  <= tmo_cnt_d;
`ifdef UART_ARB_LOCK_EN
            lock_q     <= lock_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        tx_data_d  = tx_data_q;
        req_ack_d  = '0;
        tx_start_d = 1'b0;
        tmo_cnt_d  = tmo_cnt_q;
`ifdef UART_ARB_LOCK_EN
        lock_d     = lock_q;
`endif
        unique case (state_q)
            IDLE: begin
                // Byte, ack and start are registered on the IDLE->GRANT edge so
                // tx_data is already valid while tx_start is high.
                if (arb_found && !tx_busy) begin
                    state_d    = GRANT;
                    tx_data_d  = req_data[8*int'(arb_g) +: 8];
                    grant_id_d = arb_g;
                    req_ack_d  = NUM_REQ'(1) << arb_g;
                    tx_start_d = 1'b1;
                    if (!lock_active) begin
                        rr_ptr_d = rr_next(arb_g, NUM_REQ);
                    end
                end
            end
            GRANT: begin
                state_d   = WAIT_HI;
                tmo_cnt_d = '0;
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_d = WAIT_LO;
                end else if (tmo_cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    state_d = IDLE;
`ifdef UART_ARB_LOCK_EN
                    lock_d  = 1'b0;
`endif
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    state_d = IDLE;
`ifdef UART_ARB_LOCK_EN
                    lock_d  = |(req_lock & grant_mask);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ack  = req_ack_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign grant_id = grant_id_q;
    assign arb_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queue-driven requesters, a uart_tx busy
// model, a start monitor, and one task per scenario with inline checks.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_lock;
    logic [N-1:0]   req_ack;
    logic           tx_busy;
    logic [7:0]     tx_data;
    logic           tx_start;
    logic [2:0]     grant_id;
    logic           arb_busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_lock  (req_lock),
        .req_ack   (req_ack),
        .tx_busy   (tx_busy),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .grant_id  (grant_id),
        .arb_busy  (arb_busy)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Requester queues: valid while bytes remain, next byte shown right after ack.
    logic [7:0] q_data [N][16];
    logic       q_lock [N][16];
    int         q_cnt  [N];
    int         q_idx  [N];

    always_comb begin
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (q_idx[i] < q_cnt[i]);
            if (req_valid[i]) req_data[8*i +: 8] = q_data[i][q_idx[i]];
        end
    end

    // The lock flag that travelled with the most recently acked byte stays presented.
    initial begin
        req_lock = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (req_ack[i]) begin
                    req_lock[i] = q_lock[i][q_idx[i]];
                    q_idx[i]++;
                end
            end
        end
    end

    // uart_tx model: busy rises one cycle after tx_start and stays high 20 cycles.
    int   mode = 0;
    logic model_busy = 1'b0;
    logic manual_en = 1'b0;
    logic manual_busy = 1'b0;
    assign tx_busy = manual_en ? manual_busy : model_busy;

    initial begin
        int   cnt;
        logic pend;
        cnt  = 0;
        pend = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (pend) begin
                model_busy = 1'b1;
                cnt        = 20;
                pend       = 1'b0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) model_busy = 1'b0;
            end
            if (tx_start && mode == 0) pend = 1'b1;
        end
    end

    int log_id[$];
    int log_data[$];
    int log_cyc[$];
    int ack_total = 0;

    initial forever begin
        @(negedge clk);
        if (tx_start) begin
            log_id.push_back(int'(grant_id));
            log_data.push_back(int'(tx_data));
            log_cyc.push_back(cyc);
        end
        for (int i = 0; i < N; i++) if (req_ack[i]) ack_total++;
    end

    task automatic push(input int i, input logic [7:0] d, input logic l);
        q_data[i][q_cnt[i]] = d;
        q_lock[i][q_cnt[i]] = l;
        q_cnt[i]++;
    endtask

    function automatic bit all_done();
        for (int i = 0; i < N; i++) if (q_idx[i] != q_cnt[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input int max_cyc, input string name);
        bit ok = 1'b0;
        for (int n = 0; n < max_cyc; n++) begin
            @(negedge clk);
            if (all_done() && !arb_busy && !tx_busy) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: not idle after %0d cycles", name, max_cyc);
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ack, tx_start, tx_data, grant_id, arb_busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b start=%b data=%h gid=%0d busy=%b, want all 0",
                     req_ack, tx_start, tx_data, grant_id, arb_busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (arb_busy !== 1'b0 || tx_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b start=%b, want 0 0", arb_busy, tx_start);
        end
        $display("test_reset: done");
    endtask

    task automatic test_round_robin();
        int base = log_id.size();
        int exp_id[8]   = '{0, 1, 2, 3, 0, 1, 2, 3};
        int exp_data[8] = '{'h10, 'h11, 'h12, 'h13, 'h20, 'h21, 'h22, 'h23};
        for (int i = 0; i < N; i++) begin
            push(i, 8'(8'h10 + i), 1'b0);
            push(i, 8'(8'h20 + i), 1'b0);
        end
        wait_idle(400, "rr_idle");
        checks++;
        if (log_id.size() != base + 8) begin
            errors++;
            $display("FAIL rr_count: got %0d starts, want 8", log_id.size() - base);
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (log_id[base+k] != exp_id[k] || log_data[base+k] != exp_data[k]) begin
                    errors++;
                    $display("FAIL rr_grant[%0d]: id=%0d data=%h, want id=%0d data=%h",
                             k, log_id[base+k], log_data[base+k], exp_id[k], exp_data[k]);
                end
                $display("rr grant %0d: id=%0d data=%h", k, log_id[base+k], log_data[base+k]);
            end
            checks++;
            if (log_cyc[base+1] - log_cyc[base] != 23 || log_cyc[base+4] - log_cyc[base+3] != 23) begin
                errors++;
                $display("FAIL rr_gap: gaps %0d and %0d, want 23 and 23",
                         log_cyc[base+1] - log_cyc[base], log_cyc[base+4] - log_cyc[base+3]);
            end
        end
    endtask

    task automatic test_single();
        int base = log_id.size();
        int acks = ack_total;
        int busy_cyc = 1;
        push(2, 8'hA5, 1'b0);
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b1 || req_ack !== 4'b0100 || grant_id !== 3'd2 || tx_data !== 8'hA5) begin
            errors++;
            $display("FAIL single_grant: start=%b ack=%b gid=%0d data=%h, want 1 0100 2 a5",
                     tx_start, req_ack, grant_id, tx_data);
        end
        for (int n = 0; n < 100 && arb_busy; n++) begin
            @(negedge clk);
            if (arb_busy) busy_cyc++;
        end
        checks++;
        if (busy_cyc != 22) begin
            errors++;
            $display("FAIL single_busy_len: arb_busy high %0d cycles, want 22", busy_cyc);
        end
        wait_idle(50, "single_idle");
        checks++;
        if (log_id.size() - base != 1 || ack_total - acks != 1) begin
            errors++;
            $display("FAIL single_once: starts=%0d acks=%0d, want 1 1",
                     log_id.size() - base, ack_total - acks);
        end
        checks++;
        if (tx_data !== 8'hA5 || grant_id !== 3'd2) begin
            errors++;
            $display("FAIL single_hold: data=%h gid=%0d, want a5 2", tx_data, grant_id);
        end
        $display("single: id=2 data=a5 busy_cycles=%0d", busy_cyc);
    endtask

    task automatic test_busy_at_reset();
        int starts = 0;
        manual_en   = 1'b1;
        manual_busy = 1'b1;
        rst_n       = 1'b0;
        push(0, 8'h3C, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (tx_start) starts++;
        end
        checks++;
        if (starts != 0 || arb_busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_hold: starts=%0d arb_busy=%b while tx_busy high, want 0 0", starts, arb_busy);
        end
        manual_busy = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b1 || req_ack !== 4'b0001 || tx_data !== 8'h3C) begin
            errors++;
            $display("FAIL busy_release: start=%b ack=%b data=%h, want 1 0001 3c", tx_start, req_ack, tx_data);
        end
        manual_en = 1'b0;
        wait_idle(100, "busy_idle");
        $display("busy_at_reset: grant after tx_busy fall, data=%h", tx_data);
    endtask

    task automatic test_timeout();
        int base = log_id.size();
        mode = 1;
        push(1, 8'h61, 1'b0);
        push(2, 8'h62, 1'b0);
        wait_idle(200, "tmo_idle");
        checks++;
        if (log_id.size() != base + 2) begin
            errors++;
            $display("FAIL tmo_count: got %0d starts, want 2", log_id.size() - base);
        end else begin
            checks++;
            if (log_id[base] != 1 || log_id[base+1] != 2 || log_data[base+1] != 'h62) begin
                errors++;
                $display("FAIL tmo_order: ids %0d,%0d data2=%h, want 1,2 62",
                         log_id[base], log_id[base+1], log_data[base+1]);
            end
            checks++;
            if (log_cyc[base+1] - log_cyc[base] != 18) begin
                errors++;
                $display("FAIL tmo_gap: %0d cycles between starts, want 18", log_cyc[base+1] - log_cyc[base]);
            end
            $display("timeout: ids %0d,%0d gap=%0d", log_id[base], log_id[base+1], log_cyc[base+1] - log_cyc[base]);
        end
        mode = 0;
    endtask

    task automatic test_reset_mid_frame();
        int base;
        push(0, 8'h50, 1'b0);
        push(1, 8'h51, 1'b0);
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b1 || grant_id !== 3'd0 || tx_data !== 8'h50) begin
            errors++;
            $display("FAIL mid_first: start=%b gid=%0d data=%h, want 1 0 50", tx_start, grant_id, tx_data);
        end
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ack, tx_start, tx_data, grant_id, arb_busy} !== '0) begin
            errors++;
            $display("FAIL mid_async: ack=%b start=%b data=%h gid=%0d busy=%b, want all 0",
                     req_ack, tx_start, tx_data, grant_id, arb_busy);
        end
        push(0, 8'h52, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = log_id.size();
        wait_idle(300, "mid_idle");
        checks++;
        if (log_id.size() != base + 2) begin
            errors++;
            $display("FAIL mid_count: got %0d starts, want 2", log_id.size() - base);
        end else begin
            checks++;
            if (log_id[base] != 0 || log_data[base] != 'h52 || log_id[base+1] != 1 || log_data[base+1] != 'h51) begin
                errors++;
                $display("FAIL mid_order: %0d/%h then %0d/%h, want 0/52 then 1/51",
                         log_id[base], log_data[base], log_id[base+1], log_data[base+1]);
            end
            $display("reset_mid: after release %0d/%h then %0d/%h",
                     log_id[base], log_data[base], log_id[base+1], log_data[base+1]);
        end
    endtask

    task automatic test_lock();
        int base;
`ifdef UART_ARB_LOCK_EN
        int exp_id[5]   = '{1, 1, 1, 3, 0};
        int exp_data[5] = '{'h41, 'h42, 'h43, 'h33, 'h31};
`else
        int exp_id[5]   = '{1, 3, 0, 1, 1};
        int exp_data[5] = '{'h41, 'h33, 'h31, 'h42, 'h43};
`endif
        reset_dut();
        push(0, 8'h30, 1'b0);
        wait_idle(100, "lock_prep");
        base = log_id.size();
        push(1, 8'h41, 1'b1);
        push(1, 8'h42, 1'b1);
        push(1, 8'h43, 1'b0);
        push(0, 8'h31, 1'b0);
        push(3, 8'h33, 1'b0);
        wait_idle(1000, "lock_idle");
        checks++;
        if (log_id.size() != base + 5) begin
            errors++;
            $display("FAIL lock_count: got %0d starts, want 5", log_id.size() - base);
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (log_id[base+k] != exp_id[k] || log_data[base+k] != exp_data[k]) begin
                    errors++;
                    $display("FAIL lock_grant[%0d]: id=%0d data=%h, want id=%0d data=%h",
                             k, log_id[base+k], log_data[base+k], exp_id[k], exp_data[k]);
                end
                $display("lock grant %0d: id=%0d data=%h", k, log_id[base+k], log_data[base+k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_busy_at_reset();
        test_timeout();
        test_reset_mid_frame();
        test_lock();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
